uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver stage that consumes the line driven by `uart_tx` (loopback or remote peer) and delivers parallel bytes to the host side. Oversamples `i_rx_serial` using a 16x baud tick, recovers 5–8 data bits LSB-first, optional even/odd parity and one stop bit, and presents each word on a valid/ready handshake. It reports parity, framing and overrun errors and drives `o_rts_n` for flow control toward the transmitting peer's `i_cts_n`.

## Interface
- `OVERSAMPLE`, 16: `rx_tick` pulses per bit period; even, ≥8.
- `clk  in  1`: system clock; all logic on rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `rx_tick  in  1`: one-`clk` strobe at OVERSAMPLE × baud.
- `i_num_bit_data  in  2`: data bits per frame. 00 = 5, 01 = 6, 10 = 7, 11 = 8.
- `i_parity_en  in  1`: parity bit present.
- `i_parity_type  in  1`: 0 = even, 1 = odd.
- `i_rx_serial  in  1`: asynchronous serial line; idle high.
- `i_rx_ready  in  1`: consumer accepts the word.
- `o_rx_data  out  8`: received word, zero-extended above the configured width.
- `o_rx_valid  out  1`: word and error flags are valid.
- `o_parity_err  out  1`: parity mismatch. Qualified by `o_rx_valid`.
- `o_frame_err  out  1`: stop bit sampled low. Qualified by `o_rx_valid`.
- `o_overrun  out  1`: one-`clk` pulse when a completed frame is dropped.
- `o_rts_n  out  1`: 0 = peer may send; 1 = hold.

## Operation
- **Input synchronizer:** `i_rx_serial` passes through a 2-flop synchronizer. Both flops reset to 1.
- **Tick counter:** 4-bit counter, advanced only on `rx_tick`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - Waits for a falling edge (1→0) on the synchronized line.
  - On that edge: clear the tick counter and enter START.
  - Also latch `i_num_bit_data`, `i_parity_en` and `i_parity_type`. Config changes mid-frame are ignored.
- **START:**
  - On the tick where the count reaches OVERSAMPLE/2−1, sample the line.
  - Line high: false start; return to IDLE with no outputs changed.
  - Line low: clear the counter and enter DATA.
- **DATA:**
  - Sample every OVERSAMPLE ticks; this is mid-bit.
  - Shift into bit index 0..N−1, LSB first.
  - After N samples: go to PARITY if parity is enabled, else STOP.
- **PARITY:**
  - Sample one bit.
  - Expected value is XOR of the N data bits, inverted when odd parity is selected.
  - A mismatch sets the internal parity flag.
- **STOP:**
  - Sample one bit; low sets the internal frame flag.
  - Always return to IDLE.
  - A held-low break does not retrigger, because IDLE needs a 1→0 edge.
- **Output handshake:**
  - The word transfers when `o_rx_valid & i_rx_ready` on a `clk` edge; `o_rx_valid` drops the next cycle unless a new word loads in that same cycle.
  - `o_rx_data` and the error flags are held stable while `o_rx_valid` is high.
  - When the stop sample is taken and the output slot is free, load data and flags and set `o_rx_valid`. A slot being released by a transfer in that same cycle counts as free.
  - Otherwise, discard the new frame, keep the old word, and pulse `o_overrun`.
  - A frame with a framing error is still delivered, with `o_frame_err` = 1.
- **Flow control:** `o_rts_n` is registered and equals `o_rx_valid`. It deasserts one `clk` after the slot fills.

## Timing
- **Reset values:**
  - State IDLE, counters 0.
  - `o_rx_data` = 0.
  - `o_rx_valid`, `o_parity_err`, `o_frame_err` and `o_overrun` = 0.
  - `o_rts_n` = 1; it falls to 0 on the first `clk` after reset release.
- **Reset mid-frame:** abort immediately; no partial word and no error is reported.
- **Start detect latency:** 2 `clk` (synchronizer) + 1 `clk` edge detect after the line falls.
- **First data sample:** (OVERSAMPLE/2 + OVERSAMPLE) ticks after start detect.
- **Output latency:** `o_rx_valid` rises 1 `clk` after the `rx_tick` that samples the stop bit.
- **Frame length:** (1 + N + P + 1) bit periods. The next start edge is accepted from the `clk` after the stop sample, giving mid-stop-bit resync.
- **Tolerance:** baud mismatch up to ±3% is received without error at OVERSAMPLE = 16.

## Test plan
Bench configuration for all cases: `rx_tick` every 4 `clk`, so 1 bit = 64 `clk`.
- **8N1:** line drives 0x55 → exactly one `o_rx_valid`, `o_rx_data` = 0x55, both error flags 0.
- **5N1:** line drives bits of 0xFF, five data bits → `o_rx_data` = 0x1F.
- **8E1 / 8O1:**
  - 0xAA with parity bit 0, even mode → no error.
  - Same frame in odd mode → `o_parity_err` = 1 and data = 0xAA.
- **Glitch and framing:**
  - Line low for 4 `rx_tick` then high → no `o_rx_valid`; FSM back in IDLE.
  - 0x3C with stop bit 0 → `o_frame_err` = 1.
- **Overrun / RTS:**
  - Hold `i_rx_ready` = 0 and send 0x11 then 0x22 → `o_rts_n` = 1 after the first word, one `o_overrun` pulse, `o_rx_data` stays 0x11.
  - Assert `i_rx_ready` → `o_rx_valid` falls, `o_rts_n` returns to 0.
- **Reset mid-frame:**
  - Pulse `rst` during the DATA bits of 0x99 → outputs at reset values, no valid.
  - A following clean 0x99 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver.
// Recovers 5-8 data bits (LSB first), an optional even/odd parity bit and
// one stop bit from i_rx_serial using an OVERSAMPLE x baud strobe, then
// offers the word on a valid/ready handshake.
//
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   rx_tick          one-clk strobe at OVERSAMPLE x baud
//   i_num_bit_data   data bits per frame: 00=5, 01=6, 10=7, 11=8
//   i_parity_en      parity bit present
//   i_parity_type    0 = even, 1 = odd
//   i_rx_serial      asynchronous serial line, idle high
//   i_rx_ready       consumer accepts the word
//   o_rx_data        received word, zero-extended above the configured width
//   o_rx_valid       word and error flags valid
//   o_parity_err     parity mismatch (qualified by o_rx_valid)
//   o_frame_err      stop bit sampled low (qualified by o_rx_valid)
//   o_overrun        one-clk pulse when a completed frame is dropped
//   o_rts_n          0 = peer may send, 1 = hold
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_tick,
  input  logic [1:0] i_num_bit_data,
  input  logic       i_parity_en,
  input  logic       i_parity_type,
  input  logic       i_rx_serial,
  input  logic       i_rx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_rts_n
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic             rx_sync_p0, rx_sync_p1, rx_prev_p2;
  logic [2:0]       state;
  logic [CNT_W-1:0] tick_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       last_idx;
  logic             par_en_q, par_odd_q;
  logic [7:0]       shift_q;
  logic             par_err_q;

  logic rx_bit, start_edge, mid_bit, stop_done, slot_free;

  // Stage p0/p1: two-flop synchronizer; p2: previous value for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b1;
    end else begin
      rx_sync_p0 <= i_rx_serial;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev_p2 <= rx_sync_p1;
    end
  end

  assign rx_bit     = rx_sync_p1;
  assign start_edge = rx_prev_p2 & ~rx_sync_p1;
  // START samples half a bit in; every later state samples one full bit on.
  assign mid_bit    = rx_tick && (tick_cnt == ((state == S_START) ? HALF_M1 : FULL_M1));
  assign stop_done  = mid_bit && (state == S_STOP);
  assign slot_free  = !o_rx_valid || i_rx_ready;

  // Frame sequencing: state, tick counter, bit index, latched configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      last_idx  <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else begin
      if (state != S_IDLE && rx_tick)
        tick_cnt <= mid_bit ? '0 : tick_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            tick_cnt  <= '0;
            bit_idx   <= '0;
            last_idx  <= 3'd4 + {1'b0, i_num_bit_data};
            par_en_q  <= i_parity_en;
            par_odd_q <= i_parity_type;
            state     <= S_START;
          end
        end
        S_START: begin
          if (mid_bit)
            state <= rx_bit ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (mid_bit) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == last_idx)
              state <= par_en_q ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (mid_bit)
            state <= S_STOP;
        end
        S_STOP: begin
          if (mid_bit)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data capture: bits land at their index so unused upper bits stay zero
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start_edge) begin
      shift_q   <= '0;
      par_err_q <= 1'b0;
    end else if (mid_bit && state == S_DATA) begin
      shift_q[bit_idx] <= rx_bit;
    end else if (mid_bit && state == S_PARITY) begin
      par_err_q <= rx_bit ^ (^shift_q) ^ par_odd_q;
    end
  end

  // Output slot: load on stop sample when free, otherwise flag an overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_rts_n      <= 1'b1;
    end else begin
      o_overrun <= 1'b0;
      if (stop_done && slot_free) begin
        o_rx_data    <= shift_q;
        o_parity_err <= par_err_q;
        o_frame_err  <= ~rx_bit;
        o_rx_valid   <= 1'b1;
      end else begin
        if (o_rx_valid && i_rx_ready)
          o_rx_valid <= 1'b0;
        if (stop_done)
          o_overrun <= 1'b1;
      end
      o_rts_n <= o_rx_valid;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with rx_tick every 4 clk
// (one bit = 64 clk). Directed vector table, randomized frames against a
// frame-level reference model, and hand-written multi-cycle sequences.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_tick = 1'b0;
  logic [1:0] tick_div = 2'd0;
  logic [1:0] i_num_bit_data = 2'd3;
  logic       i_parity_en = 1'b0;
  logic       i_parity_type = 1'b0;
  logic       i_rx_serial = 1'b1;
  logic       i_rx_ready = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, o_parity_err, o_frame_err, o_overrun, o_rts_n;

  int checks = 0;
  int failures = 0;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .rx_tick(rx_tick),
    .i_num_bit_data(i_num_bit_data), .i_parity_en(i_parity_en),
    .i_parity_type(i_parity_type), .i_rx_serial(i_rx_serial),
    .i_rx_ready(i_rx_ready), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
    .o_parity_err(o_parity_err), .o_frame_err(o_frame_err),
    .o_overrun(o_overrun), .o_rts_n(o_rts_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div <= tick_div + 2'd1;
    rx_tick  <= (tick_div == 2'd3);
  end

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  typedef struct {
    string      name;
    logic [7:0] b;
    logic [1:0] ncode;
    logic       pen;
    logic       ptype;
    logic       pbit;
    logic       stopb;
    word_t      exp;
  } vec_t;

  word_t got_q[$];
  int    ovr_cnt = 0;

  // Every accepted handshake and every overrun pulse is recorded here.
  always @(negedge clk) begin
    if (!rst && o_rx_valid && i_rx_ready)
      got_q.push_back('{d: o_rx_data, pe: o_parity_err, fe: o_frame_err});
    if (o_overrun)
      ovr_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int cyc);
    i_rx_serial = v;
    repeat (cyc) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int n, input logic pen,
                            input logic pbit, input logic stopb);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < n; i++) hold(b[i], BIT_CLK);
    if (pen) hold(pbit, BIT_CLK);
    hold(stopb, BIT_CLK);
    hold(1'b1, BIT_CLK);
  endtask

  // Frame-level reference: keep N low bits, compare parity bit against the
  // XOR of those bits (inverted for odd), stop low means framing error.
  function automatic word_t model(input logic [7:0] b, input logic [1:0] ncode,
                                  input logic pen, input logic ptype,
                                  input logic pbit, input logic stopb);
    int    n;
    logic [7:0] mask;
    word_t w;
    n    = 5 + int'(ncode);
    mask = 8'((1 << n) - 1);
    w.d  = b & mask;
    w.pe = pen && (pbit != ((^w.d) ^ ptype));
    w.fe = !stopb;
    return w;
  endfunction

  task automatic run_frame(input string name, input logic [7:0] b, input logic [1:0] ncode,
                           input logic pen, input logic ptype, input logic pbit,
                           input logic stopb, input word_t exp);
    int base;
    i_num_bit_data = ncode;
    i_parity_en    = pen;
    i_parity_type  = ptype;
    base = got_q.size();
    send_frame(b, 5 + int'(ncode), pen, pbit, stopb);
    chk({name, ".count"}, got_q.size() - base, 1);
    if (got_q.size() > base) begin
      chk({name, ".data"}, {24'd0, got_q[base].d}, {24'd0, exp.d});
      chk({name, ".perr"}, {31'd0, got_q[base].pe}, {31'd0, exp.pe});
      chk({name, ".ferr"}, {31'd0, got_q[base].fe}, {31'd0, exp.fe});
    end
  endtask

  vec_t vecs[7];

  initial begin
    int base, ovr0;
    vecs[0] = '{"8N1_55",  8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, '{8'h55, 1'b0, 1'b0}};
    vecs[1] = '{"5N1_FF",  8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, '{8'h1F, 1'b0, 1'b0}};
    vecs[2] = '{"8E1_AA",  8'hAA, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, '{8'hAA, 1'b0, 1'b0}};
    vecs[3] = '{"8O1_AA",  8'hAA, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, '{8'hAA, 1'b1, 1'b0}};
    vecs[4] = '{"8N0_3C",  8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, '{8'h3C, 1'b0, 1'b1}};
    vecs[5] = '{"7N1_99",  8'h99, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, '{8'h19, 1'b0, 1'b0}};
    vecs[6] = '{"6E1_5A",  8'h5A, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, '{8'h1A, 1'b0, 1'b0}};

    // Reset values
    repeat (4) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, o_rx_valid}, 0);
    chk("rst.data", {24'd0, o_rx_data}, 0);
    chk("rst.perr", {31'd0, o_parity_err}, 0);
    chk("rst.ferr", {31'd0, o_frame_err}, 0);
    chk("rst.ovr", {31'd0, o_overrun}, 0);
    chk("rst.rts", {31'd0, o_rts_n}, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.rts_release", {31'd0, o_rts_n}, 0);
    hold(1'b1, 2 * BIT_CLK);

    // Directed vectors
    foreach (vecs[i])
      run_frame(vecs[i].name, vecs[i].b, vecs[i].ncode, vecs[i].pen, vecs[i].ptype,
                vecs[i].pbit, vecs[i].stopb, vecs[i].exp);

    // Glitch: 4 ticks low, then high; nothing delivered, next frame clean
    base = got_q.size();
    hold(1'b0, 16);
    hold(1'b1, 12 * BIT_CLK);
    chk("glitch.count", got_q.size() - base, 0);
    run_frame("after_glitch", 8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1,
              '{8'hC3, 1'b0, 1'b0});

    // Randomized frames against the reference model
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      logic [1:0] nc;
      logic pen, pt, pb, sb;
      b  = 8'($urandom);
      nc = 2'($urandom_range(0, 3));
      pen = 1'($urandom);
      pt = 1'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      run_frame("rand", b, nc, pen, pt, pb, sb, model(b, nc, pen, pt, pb, sb));
    end

    // Overrun and flow control
    i_num_bit_data = 2'd3;
    i_parity_en    = 1'b0;
    i_rx_ready     = 1'b0;
    base = got_q.size();
    ovr0 = ovr_cnt;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    #1;
    chk("ovr.valid1", {31'd0, o_rx_valid}, 1);
    chk("ovr.data1", {24'd0, o_rx_data}, 32'h11);
    chk("ovr.rts1", {31'd0, o_rts_n}, 1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    #1;
    chk("ovr.pulses", ovr_cnt - ovr0, 1);
    chk("ovr.valid2", {31'd0, o_rx_valid}, 1);
    chk("ovr.data2", {24'd0, o_rx_data}, 32'h11);
    chk("ovr.rts2", {31'd0, o_rts_n}, 1);
    @(posedge clk);
    #1 i_rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ovr.valid_drop", {31'd0, o_rx_valid}, 0);
    chk("ovr.rts_back", {31'd0, o_rts_n}, 0);
    chk("ovr.accepted", got_q.size() - base, 1);
    if (got_q.size() > base)
      chk("ovr.accepted_data", {24'd0, got_q[base].d}, 32'h11);

    // Reset during the data bits of 0x99
    base = got_q.size();
    hold(1'b0, BIT_CLK);
    hold(1'b1, BIT_CLK);
    hold(1'b0, BIT_CLK / 2);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.valid", {31'd0, o_rx_valid}, 0);
    chk("midrst.data", {24'd0, o_rx_data}, 0);
    chk("midrst.perr", {31'd0, o_parity_err}, 0);
    chk("midrst.ferr", {31'd0, o_frame_err}, 0);
    chk("midrst.rts", {31'd0, o_rts_n}, 1);
    i_rx_serial = 1'b1;
    rst = 1'b0;
    hold(1'b1, 12 * BIT_CLK);
    chk("midrst.count", got_q.size() - base, 0);
    run_frame("after_rst_99", 8'h99, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1,
              '{8'h99, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
